// File: rtl/ad_cmd_pkg.sv
// Shared types and constants for the A/D command store and sequencer.
package ad_cmd_pkg;

  localparam int LANE_W     = 8;
  localparam int PASS_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } seq_state_e;

endpackage

// File: rtl/ad_cmd_seq_ram_lane.sv
// One 8-bit byte lane of the command store: one write port, a host read port with
// registered (read-before-write) data and a sequencer read port addressed by the pointer register.
module ad_cmd_seq_ram_lane
  import ad_cmd_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [LANE_W-1:0] i_wdata,
  output logic [LANE_W-1:0] o_host_rdata,
  input  logic [ADDR_W-1:0] i_seq_addr,
  output logic [LANE_W-1:0] o_seq_rdata
);

  logic [LANE_W-1:0] r_mem [DEPTH];
  logic [LANE_W-1:0] r_host_rdata;

  // NOTE: the storage array has no reset so it maps onto RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_host_addr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) r_host_rdata <= '0;
    else       r_host_rdata <= r_mem[i_host_addr];
  end

  assign o_host_rdata = r_host_rdata;
  assign o_seq_rdata  = r_mem[i_seq_addr];

endmodule

// File: rtl/ad_cmd_seq_ram.sv
// A/D command store with a valid/ready command sequencer (IDLE -> FETCH -> PRESENT).
// Optional pass counter output enabled by defining AD_CMD_SEQ_PASS_CNT_EN.
module ad_cmd_seq_ram
  import ad_cmd_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic [BE_W-1:0]   writebyteenable,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic              seq_start,
  input  logic              seq_stop,
  input  logic [ADDR_W:0]   seq_len,
  input  logic              seq_loop,
  output logic              cmd_valid,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_ready,
  output logic              seq_busy,
  output logic              seq_done
`ifdef AD_CMD_SEQ_PASS_CNT_EN
  ,
  output logic [PASS_CNT_W-1:0] pass_count
`endif
);

  seq_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_len;
  logic              r_loop;
  logic              r_stop_pend;
  logic              r_done;
  logic [DATA_W-1:0] r_cmd_data;
  logic [DATA_W-1:0] w_seq_word;
  logic              w_start, w_hs, w_last, w_end;

  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    ad_cmd_seq_ram_lane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
      .clk          (clk),
      .reset        (reset),
      .i_we         (write && writebyteenable[g]),
      .i_host_addr  (address),
      .i_wdata      (writedata[g*LANE_W +: LANE_W]),
      .o_host_rdata (readdata[g*LANE_W +: LANE_W]),
      .i_seq_addr   (r_ptr),
      .o_seq_rdata  (w_seq_word[g*LANE_W +: LANE_W])
    );
  end

  assign w_start = (r_state == IDLE) && seq_start && (seq_len != '0);
  assign w_hs    = (r_state == PRESENT) && cmd_ready;
  assign w_last  = ({1'b0, r_ptr} == (r_len - (ADDR_W+1)'(1)));
  // A stop raised in the handshake cycle itself also ends the sequence there.
  assign w_end   = r_stop_pend || seq_stop || (w_last && !r_loop);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = PRESENT;
      PRESENT: if (w_hs) w_state_nxt = w_end ? IDLE : FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_len       <= '0;
      r_loop      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_data  <= '0;
    end else begin
      r_done <= w_hs && w_end;
      if (w_start) begin
        r_len       <= seq_len;
        r_loop      <= seq_loop;
        r_ptr       <= '0;
        r_stop_pend <= 1'b0;
      end else if (r_state != IDLE && seq_stop) begin
        r_stop_pend <= 1'b1;
      end
      // Captured only on leaving FETCH, so host writes cannot disturb a presented word.
      if (r_state == FETCH) r_cmd_data <= w_seq_word;
      if (w_hs) r_ptr <= w_last ? '0 : r_ptr + ADDR_W'(1);
    end
  end

  assign cmd_valid = (r_state == PRESENT);
  assign cmd_data  = r_cmd_data;
  assign seq_busy  = (r_state != IDLE);
  assign seq_done  = r_done;

`ifdef AD_CMD_SEQ_PASS_CNT_EN
  logic [PASS_CNT_W-1:0] r_pass_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_start)                      r_pass_cnt <= '0;
    else if (w_hs && w_last && r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + PASS_CNT_W'(1);
  end

  assign pass_count = r_pass_cnt;
`endif

endmodule

// File: tb/tb_ad_cmd_seq_ram.sv
// Scoreboard bench for ad_cmd_seq_ram: stimulus pushes expected words, a negedge monitor checks them.
module tb_ad_cmd_seq_ram;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int BE_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic              write = 1'b0;
  logic [BE_W-1:0]   writebyteenable = '0;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;
  logic              seq_start = 1'b0;
  logic              seq_stop = 1'b0;
  logic [ADDR_W:0]   seq_len = '0;
  logic              seq_loop = 1'b0;
  logic              cmd_valid;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready = 1'b0;
  logic              seq_busy;
  logic              seq_done;
`ifdef AD_CMD_SEQ_PASS_CNT_EN
  logic [15:0]       pass_count;
`endif

  ad_cmd_seq_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .write           (write),
    .writebyteenable (writebyteenable),
    .writedata       (writedata),
    .readdata        (readdata),
    .seq_start       (seq_start),
    .seq_stop        (seq_stop),
    .seq_len         (seq_len),
    .seq_loop        (seq_loop),
    .cmd_valid       (cmd_valid),
    .cmd_data        (cmd_data),
    .cmd_ready       (cmd_ready),
    .seq_busy        (seq_busy),
    .seq_done        (seq_done)
`ifdef AD_CMD_SEQ_PASS_CNT_EN
    ,
    .pass_count      (pass_count)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] cmd_q[$];
  logic [15:0] rd_q[$];
  int          hs_cyc[$];
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          rd_req = 1'b0;
  bit          rd_pend = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: samples mid-cycle, pops expected values as the DUT presents outputs.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) fail_now("readdata_unexpected");
      else check("readdata", readdata, rd_q.pop_front());
    end
    rd_pend = rd_req;
    if (cmd_valid && cmd_ready) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (cmd_q.size() == 0) fail_now("cmd_unexpected");
      else check("cmd_data", cmd_data, cmd_q.pop_front());
    end
    if (seq_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                            input logic [DATA_W-1:0] d);
    address = a; writebyteenable = be; writedata = d; write = 1'b1;
    step();
    write = 1'b0; writebyteenable = '0;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    address = a; rd_req = 1'b1; rd_q.push_back(exp);
    step();
    rd_req = 1'b0;
  endtask

  task automatic start_seq(input logic [ADDR_W:0] len, input logic loop);
    seq_len = len; seq_loop = loop; seq_start = 1'b1;
    step();
    seq_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (seq_busy && n < 200) begin step(); n++; end
    if (seq_busy) fail_now({name, "_idle_timeout"});
    step(2);
  endtask

  task automatic wait_present(input string name, input int hs_target);
    int n = 0;
    while (!(cmd_valid && hs_cnt == hs_target) && n < 200) begin step(); n++; end
    if (n >= 200) fail_now({name, "_present_timeout"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, s_cyc;

    // Reset state
    step(3);
    check("rst_readdata", readdata, 16'h0);
    check("rst_cmd_data", cmd_data, 16'h0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_seq_busy", seq_busy, 1'b0);
    check("rst_seq_done", seq_done, 1'b0);
    reset = 1'b0;
    step();

    // Byte-enabled writes and 1-cycle-latency reads
    host_write(3'd2, 2'b11, 16'h5678);
    host_write(3'd2, 2'b01, 16'h1234);
    host_read(3'd2, 16'h5634);
    host_write(3'd2, 2'b10, 16'hABCD);
    host_read(3'd2, 16'hAB34);
    host_write(3'd3, 2'b11, 16'hBEEF);
    address = 3'd3; writedata = 16'h1111; writebyteenable = 2'b11; write = 1'b1;
    rd_req = 1'b1; rd_q.push_back(16'hBEEF);
    step();
    write = 1'b0; writebyteenable = '0; rd_req = 1'b0;
    host_read(3'd3, 16'h1111);
    step(2);

    // Single pass, cmd_ready held high: 2-cycle spacing, one seq_done
    for (int i = 0; i < 4; i++) host_write(i[2:0], 2'b11, 16'hA000 + 16'(i));
    for (int i = 0; i < 4; i++) cmd_q.push_back(16'hA000 + 16'(i));
    cmd_ready = 1'b1;
    base = hs_cyc.size(); d0 = done_cnt; s_cyc = cyc;
    start_seq(4'd4, 1'b0);
    wait_idle("once");
    check("once_done_cnt", done_cnt - d0, 1);
    check("once_busy", seq_busy, 1'b0);
    if (hs_cyc.size() >= base + 4) begin
      check("once_first_latency", hs_cyc[base] - s_cyc, 2);
      for (int i = 0; i < 3; i++) check("once_spacing", hs_cyc[base+i+1] - hs_cyc[base+i], 2);
      check("once_done_timing", done_cyc - hs_cyc[base+3], 1);
    end else fail_now("once_hs_missing");
`ifdef AD_CMD_SEQ_PASS_CNT_EN
    check("once_pass_count", pass_count, 16'd1);
`endif

    // Looping, stop raised (ready low) during the second presentation of A001
    for (int i = 0; i < 4; i++) cmd_q.push_back(16'hA000 + 16'(i));
    cmd_q.push_back(16'hA000);
    cmd_q.push_back(16'hA001);
    base = hs_cnt; d0 = done_cnt;
    start_seq(4'd4, 1'b1);
    wait_present("loop_stop", base + 5);
    check("loop_stop_word", cmd_data, 16'hA001);
    cmd_ready = 1'b0; seq_stop = 1'b1;
    step();
    seq_stop = 1'b0;
    check("loop_stop_hold_valid", cmd_valid, 1'b1);
    step();
    cmd_ready = 1'b1;
    wait_idle("loop_stop");
    check("loop_stop_done_cnt", done_cnt - d0, 1);
    check("loop_stop_hs_cnt", hs_cnt - base, 6);
`ifdef AD_CMD_SEQ_PASS_CNT_EN
    check("loop_pass_count", pass_count, 16'd1);
`endif

    // Stalled presentation: host write to the presented word must not disturb cmd_data
    cmd_ready = 1'b0;
    cmd_q.push_back(16'hA000); cmd_q.push_back(16'hA001);
    start_seq(4'd2, 1'b0);
    wait_present("stall", hs_cnt);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) host_write(3'd0, 2'b11, 16'hFFFF);
      else step();
      check("stall_cmd_data", cmd_data, 16'hA000);
      check("stall_cmd_valid", cmd_valid, 1'b1);
    end
    cmd_ready = 1'b1;
    wait_idle("stall");
    cmd_q.push_back(16'hFFFF); cmd_q.push_back(16'hA001);
    start_seq(4'd2, 1'b0);
    wait_idle("stall_next_pass");

    // seq_len = 0 is ignored
    start_seq(4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("len0_busy", seq_busy, 1'b0);
      check("len0_valid", cmd_valid, 1'b0);
      step();
    end

    // seq_len = DEPTH wraps 7 -> 0; len change while busy ignored; stop in handshake cycle
    host_write(3'd0, 2'b11, 16'hA000);
    for (int i = 4; i < 8; i++) host_write(i[2:0], 2'b11, 16'hA000 + 16'(i));
    for (int i = 0; i < 8; i++) cmd_q.push_back(16'hA000 + 16'(i));
    cmd_q.push_back(16'hA000); cmd_q.push_back(16'hA001);
    base = hs_cnt; d0 = done_cnt;
    start_seq(4'd8, 1'b1);
    seq_len = 4'd2; seq_loop = 1'b0;
    wait_present("wrap", base + 9);
    seq_stop = 1'b1;
    step();
    seq_stop = 1'b0;
    wait_idle("wrap");
    check("wrap_hs_cnt", hs_cnt - base, 10);
    check("wrap_done_cnt", done_cnt - d0, 1);

    // Reset while presenting aborts without seq_done; memory retained
    cmd_ready = 1'b0;
    start_seq(4'd2, 1'b0);
    wait_present("rst_mid", hs_cnt);
    d0 = done_cnt;
    reset = 1'b1;
    step();
    check("rst_mid_valid", cmd_valid, 1'b0);
    check("rst_mid_busy", seq_busy, 1'b0);
    check("rst_mid_done", seq_done, 1'b0);
    check("rst_mid_cmd_data", cmd_data, 16'h0);
    reset = 1'b0;
    step(3);
    check("rst_mid_no_done", done_cnt - d0, 0);
    host_read(3'd0, 16'hA000);
    host_read(3'd7, 16'hA007);
    step(2);

    check("cmd_q_drained", cmd_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
